// File: rtl/shaper_ctrl_pkg.sv
// Shared types and constants for the trapezoidal shaper run controller.
// The default coefficient set doubles as the reset value of the active set.
package shaper_ctrl_pkg;

  localparam int K_W   = 8;
  localparam int M_W   = 12;
  localparam int LEN_W = 7;
  localparam int CNT_W = LEN_W + 4;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    FLUSH,
    RUN
  } shaper_state_t;

  localparam logic [K_W-1:0]   DEF_K   = 8'd4;
  localparam logic [LEN_W-1:0] DEF_L   = 7'd8;
  localparam logic [LEN_W-1:0] DEF_LEN = 7'd16;
  localparam logic [M_W-1:0]   DEF_M1  = 12'd200;
  localparam logic [M_W-1:0]   DEF_M2  = 12'd50;

endpackage

// File: rtl/shaper_filter_ctrl_if.sv
// Configuration offer port: a coefficient set with valid/ready and a reject pulse.
interface shaper_filter_ctrl_if;
  import shaper_ctrl_pkg::*;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [K_W-1:0]   cfg_k;
  logic [LEN_W-1:0] cfg_l;
  logic [LEN_W-1:0] cfg_len;
  logic [M_W-1:0]   cfg_m1;
  logic [M_W-1:0]   cfg_m2;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_k, cfg_l, cfg_len, cfg_m1, cfg_m2,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_k, cfg_l, cfg_len, cfg_m1, cfg_m2,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/shaper_settle_counter.sv
// Loadable saturating counter; tc flags that the next count reaches the target.
module shaper_settle_counter #(
  parameter int unsigned W = 11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] target,
  output logic         tc
);

  logic [W-1:0] cnt;
  logic [W-1:0] cnt_inc;

  always_comb begin
    cnt_inc = (cnt == '1) ? cnt : cnt + W'(1);
    tc      = (cnt_inc >= target);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en)   cnt <= cnt_inc;
  end

endmodule

// File: rtl/shaper_filter_ctrl.sv
// Run controller for the trapezoidal shaping filter: holds the active coefficient
// set and sequences clear / flush / run so valid output always has settled data.
module shaper_filter_ctrl
  import shaper_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH_MAX  = 64,
  parameter int unsigned PIPE_LAT   = 6,
  parameter int unsigned CLR_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  shaper_filter_ctrl_if.slave  cfg,
  output logic                 flt_clr_n,
  output logic [K_W-1:0]       flt_k,
  output logic [LEN_W-1:0]     flt_l,
  output logic [LEN_W-1:0]     flt_len,
  output logic [M_W-1:0]       flt_m1,
  output logic [M_W-1:0]       flt_m2,
  output logic                 flt_out_valid,
  output logic                 busy
);

  localparam logic [CNT_W-1:0] CLR_TGT  = CNT_W'(CLR_CYCLES);
  localparam logic [CNT_W-1:0] PIPE_TGT = CNT_W'(PIPE_LAT);

  shaper_state_t    state;
  shaper_state_t    state_nxt;
  logic             cfg_bad;
  logic             hs;
  logic             accept;
  logic             cnt_load;
  logic             cnt_en;
  logic             cnt_tc;
  logic [CNT_W-1:0] cnt_target;

  assign cfg.cfg_ready = (state == IDLE) || (state == RUN);

  always_comb begin
    cfg_bad = (cfg.cfg_l == '0)
           || (cfg.cfg_l >= cfg.cfg_len)
           || (32'(cfg.cfg_len) > DEPTH_MAX)
           || (cfg.cfg_len < LEN_W'(2));
    hs     = cfg.cfg_valid && cfg.cfg_ready;
    accept = hs && !cfg_bad;

    cnt_target = (state == CLEAR) ? CLR_TGT : (CNT_W'(flt_len) + PIPE_TGT);

    state_nxt = state;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    state_nxt = FLUSH;
        CLEAR:   if (cnt_tc) state_nxt = FLUSH;
        FLUSH:   if (cnt_tc) state_nxt = RUN;
        RUN:     if (accept) state_nxt = CLEAR;
        default: state_nxt = IDLE;
      endcase
    end

    // Restart the count on every entry into a counted phase.
    cnt_load = (state_nxt != state) && ((state_nxt == CLEAR) || (state_nxt == FLUSH));
    cnt_en   = (state == CLEAR) || (state == FLUSH);
  end

  shaper_settle_counter #(
    .W (CNT_W)
  ) u_settle (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val ('0),
    .en       (cnt_en),
    .target   (cnt_target),
    .tc       (cnt_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      flt_clr_n     <= 1'b0;
      flt_out_valid <= 1'b0;
      busy          <= 1'b0;
      cfg.cfg_err   <= 1'b0;
      flt_k         <= DEF_K;
      flt_l         <= DEF_L;
      flt_len       <= DEF_LEN;
      flt_m1        <= DEF_M1;
      flt_m2        <= DEF_M2;
    end else begin
      state         <= state_nxt;
      flt_clr_n     <= (state_nxt == FLUSH) || (state_nxt == RUN);
      flt_out_valid <= (state_nxt == RUN);
      busy          <= (state_nxt == CLEAR) || (state_nxt == FLUSH);
      cfg.cfg_err   <= hs && cfg_bad;
      if (accept) begin
        flt_k   <= cfg.cfg_k;
        flt_l   <= cfg.cfg_l;
        flt_len <= cfg.cfg_len;
        flt_m1  <= cfg.cfg_m1;
        flt_m2  <= cfg.cfg_m2;
      end
    end
  end

endmodule

// File: tb/tb_shaper_filter_ctrl.sv
// Scoreboard bench for shaper_filter_ctrl: a timeline model predicts every cycle,
// and a negedge monitor compares the DUT against the queued predictions.
module tb_shaper_filter_ctrl;
  import shaper_ctrl_pkg::*;

  localparam int PIPE = 6;
  localparam int CLR  = 2;
  localparam int DMAX = 64;
  localparam int D_K = 4, D_L = 8, D_LEN = 16, D_M1 = 200, D_M2 = 50;
  localparam int PH_IDLE = 0, PH_CLEAR = 1, PH_FLUSH = 2, PH_RUN = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic flt_clr_n, flt_out_valid, busy;
  logic [K_W-1:0]   flt_k;
  logic [LEN_W-1:0] flt_l, flt_len;
  logic [M_W-1:0]   flt_m1, flt_m2;

  shaper_filter_ctrl_if cfg_if ();

  shaper_filter_ctrl #(
    .DEPTH_MAX  (64),
    .PIPE_LAT   (6),
    .CLR_CYCLES (2)
  ) u_dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .cfg           (cfg_if),
    .flt_clr_n     (flt_clr_n),
    .flt_k         (flt_k),
    .flt_l         (flt_l),
    .flt_len       (flt_len),
    .flt_m1        (flt_m1),
    .flt_m2        (flt_m2),
    .flt_out_valid (flt_out_valid),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rdy, clr_n, vld, bsy, err;
    int k, l, len, m1, m2;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_pass = 0;

  // Timeline model: phases follow from the cycle index relative to clear/run marks.
  int cyc = 0;
  int clr_end = 0;
  int valid_from = 0;
  bit m_idle = 1'b1;
  int m_k = D_K, m_l = D_L, m_len = D_LEN, m_m1 = D_M1, m_m2 = D_M2;

  function automatic int phase(int c);
    if (m_idle)          return PH_IDLE;
    if (c < clr_end)     return PH_CLEAR;
    if (c < valid_from)  return PH_FLUSH;
    return PH_RUN;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
  endtask

  task automatic step(input bit en, input bit v, input int k, input int l, input int len,
                      input int m1, input int m2, output bit acc);
    int ph;
    bit hs, bad;
    exp_t e;
    enable            = en;
    cfg_if.cfg_valid  = v;
    cfg_if.cfg_k      = K_W'(k);
    cfg_if.cfg_l      = LEN_W'(l);
    cfg_if.cfg_len    = LEN_W'(len);
    cfg_if.cfg_m1     = M_W'(m1);
    cfg_if.cfg_m2     = M_W'(m2);
    @(posedge clk);
    ph  = phase(cyc);
    hs  = v && (ph == PH_IDLE || ph == PH_RUN);
    bad = (l == 0) || (l >= len) || (len > DMAX) || (len < 2);
    acc = hs && !bad;
    if (acc) begin
      m_k = k; m_l = l; m_len = len; m_m1 = m1; m_m2 = m2;
    end
    if (!en) begin
      m_idle = 1'b1;
    end else if (ph == PH_IDLE) begin
      m_idle     = 1'b0;
      clr_end    = cyc + 1;
      valid_from = cyc + 1 + m_len + PIPE;
    end else if (ph == PH_RUN && acc) begin
      clr_end    = cyc + 1 + CLR;
      valid_from = clr_end + m_len + PIPE;
    end
    cyc++;
    ph     = phase(cyc);
    e.rdy  = (ph == PH_IDLE || ph == PH_RUN);
    e.clr_n = (ph == PH_FLUSH || ph == PH_RUN);
    e.vld  = (ph == PH_RUN);
    e.bsy  = (ph == PH_CLEAR || ph == PH_FLUSH);
    e.err  = hs && bad;
    e.k = m_k; e.l = m_l; e.len = m_len; e.m1 = m_m1; e.m2 = m_m2;
    q.push_back(e);
    #1;
  endtask

  task automatic idle_steps(input int n, input bit en);
    bit a;
    for (int i = 0; i < n; i++) step(en, 1'b0, 0, 0, 0, 0, 0, a);
  endtask

  task automatic wait_run(input string name);
    bit a;
    int guard;
    guard = 0;
    while (phase(cyc) != PH_RUN && guard < 200) begin
      step(1'b1, 1'b0, 0, 0, 0, 0, 0, a);
      guard++;
    end
    if (guard >= 200) chk(name, 0, 1);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_cfg_ready"}, int'(cfg_if.cfg_ready), 1);
    chk({tag, "_flt_clr_n"}, int'(flt_clr_n), 0);
    chk({tag, "_flt_out_valid"}, int'(flt_out_valid), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_cfg_err"}, int'(cfg_if.cfg_err), 0);
    chk({tag, "_flt_k"}, int'(flt_k), D_K);
    chk({tag, "_flt_l"}, int'(flt_l), D_L);
    chk({tag, "_flt_len"}, int'(flt_len), D_LEN);
    chk({tag, "_flt_m1"}, int'(flt_m1), D_M1);
    chk({tag, "_flt_m2"}, int'(flt_m2), D_M2);
  endtask

  always @(negedge clk) begin
    if (reset && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("cfg_ready", int'(cfg_if.cfg_ready), int'(e.rdy));
      chk("flt_clr_n", int'(flt_clr_n), int'(e.clr_n));
      chk("flt_out_valid", int'(flt_out_valid), int'(e.vld));
      chk("busy", int'(busy), int'(e.bsy));
      chk("cfg_err", int'(cfg_if.cfg_err), int'(e.err));
      chk("flt_k", int'(flt_k), e.k);
      chk("flt_l", int'(flt_l), e.l);
      chk("flt_len", int'(flt_len), e.len);
      chk("flt_m1", int'(flt_m1), e.m1);
      chk("flt_m2", int'(flt_m2), e.m2);
    end
  end

  int bl[6] = '{0, 16, 5, 1, 63, 1};
  int blen[6] = '{16, 16, 65, 1, 64, 2};

  initial begin
    bit a;
    int guard;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_k = '0; cfg_if.cfg_l = '0; cfg_if.cfg_len = '0;
    cfg_if.cfg_m1 = '0; cfg_if.cfg_m2 = '0;
    #2 reset = 1'b0;
    #20 chk_reset_values("rst");
    @(negedge clk); #1 reset = 1'b1;

    // Bring-up with defaults, then the main reconfiguration.
    idle_steps(3, 1'b0);
    idle_steps(30, 1'b1);
    step(1'b1, 1'b1, 3, 8, 32, 5, 100, a);
    chk("run_accept", int'(a), 1);
    idle_steps(45, 1'b1);

    // Rejected set in RUN leaves everything alone.
    step(1'b1, 1'b1, 1, 20, 16, 1, 1, a);
    idle_steps(3, 1'b1);

    // Valid held across CLEAR/FLUSH; the second set lands on the first RUN cycle.
    step(1'b1, 1'b1, 7, 4, 16, 9, 11, a);
    guard = 0;
    a = 1'b0;
    while (!a && guard < 100) begin
      step(1'b1, 1'b1, 9, 4, 16, 7, 9, a);
      guard++;
    end
    chk("held_accept", int'(a), 1);
    idle_steps(30, 1'b1);

    // Enable dropped mid-FLUSH, then a fresh start.
    idle_steps(2, 1'b0);
    idle_steps(6, 1'b1);
    idle_steps(3, 1'b0);
    idle_steps(30, 1'b1);

    // Accept in IDLE together with enable.
    idle_steps(2, 1'b0);
    step(1'b1, 1'b1, 2, 1, 4, 3, 4, a);
    idle_steps(12, 1'b1);

    // Boundary sets offered in RUN.
    for (int i = 0; i < 6; i++) begin
      wait_run("bound_wait_run");
      step(1'b1, 1'b1, i + 1, bl[i], blen[i], 10 + i, 20 + i, a);
      idle_steps(2, 1'b1);
    end

    // Randomised traffic.
    for (int i = 0; i < 900; i++) begin
      int len;
      len = $urandom_range(0, 80);
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 5) == 0),
           $urandom_range(0, 255), $urandom_range(0, len + 1), len,
           $urandom_range(0, 4095), $urandom_range(0, 4095), a);
    end

    // Asynchronous reset in the middle of RUN.
    wait_run("reset_wait_run");
    idle_steps(2, 1'b1);
    @(negedge clk);
    #1 reset = 1'b0;
    #1 chk_reset_values("midrun_rst");
    m_idle = 1'b1;
    m_k = D_K; m_l = D_L; m_len = D_LEN; m_m1 = D_M1; m_m2 = D_M2;
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    idle_steps(25, 1'b1);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
